// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the fetch stage and the execute logic that drives redirect/halt.
// The FSM encoding and the opcode values are defined here once so both sides agree.
package fetch_prefetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int OPC_W  = 4;

    // Opcode field sits in the top bits of the instruction word.
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs between memory and decode.
// Flush empties it in one cycle; the head entry is visible combinationally.
module fetch_prefetch_unit_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction fetch: issues reads to a one-cycle instruction memory, buffers
// the words in a prefetch FIFO and hands them to decode over a valid/ready handshake.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [AW-1:0]     imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_target,
    input  logic              halt_req,
    output logic              halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INST_W + PC_W;

    // Handshake: decode takes the head on an edge where inst_valid & inst_ready; while
    // inst_valid is high and inst_ready low the head (inst_data/inst_pc) is held stable.

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_req_pc;
    logic              r_imem_en;
    logic [AW-1:0]     r_imem_addr;
    logic              r_halted;
    logic [INST_W-1:0] r_last_data;
    logic [PC_W-1:0]   r_last_pc;

    logic [EW-1:0]     w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic              w_running;
    logic              w_halt;
    logic              w_redirect;
    logic              w_flush;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CW:0]       w_occ;
    logic [CW:0]       w_limit;

    assign w_running  = (r_state == RUN);
    assign w_halt     = w_running & halt_req;
    assign w_redirect = w_running & redirect_valid & ~halt_req;
    assign w_flush    = w_halt | w_redirect;
    assign w_pop      = inst_valid & inst_ready;

    // The word returning this cycle belongs to last cycle's request; a flush drops it.
    assign w_push  = w_running & r_imem_en & ~w_flush & (~w_fifo_full | w_pop);

    // Occupancy after this edge (stored + returning - leaving) must leave room for one more.
    assign w_occ   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_imem_en};
    assign w_limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, w_pop};
    assign w_issue = w_running & ~w_flush & (w_occ < w_limit);

    fetch_prefetch_unit_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .push      (w_push),
        .push_data ({imem_rdata, r_req_pc}),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_req_pc    <= '0;
            r_imem_en   <= 1'b0;
            r_imem_addr <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= RUN;
                    r_imem_en <= 1'b0;
                end
                RUN: begin
                    if (w_halt) begin
                        r_state   <= HALTED;
                        r_halted  <= 1'b1;
                        r_imem_en <= 1'b0;
                    end else if (w_redirect) begin
                        r_pc      <= redirect_target;
                        r_imem_en <= 1'b0;
                    end else if (w_issue) begin
                        r_imem_en   <= 1'b1;
                        r_imem_addr <= r_pc[AW-1:0];
                        r_req_pc    <= r_pc;
                        r_pc        <= r_pc + 1'b1;
                    end else begin
                        r_imem_en <= 1'b0;
                    end
                end
                HALTED: begin
                    r_imem_en <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_imem_en <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last presented head so the outputs hold while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_data <= '0;
            r_last_pc   <= '0;
        end else if (!w_fifo_empty) begin
            r_last_data <= w_fifo_head[EW-1:PC_W];
            r_last_pc   <= w_fifo_head[PC_W-1:0];
        end
    end

    assign imem_en    = r_imem_en;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = ~w_fifo_empty;
    assign inst_data  = w_fifo_empty ? r_last_data : w_fifo_head[EW-1:PC_W];
    assign inst_pc    = w_fifo_empty ? r_last_pc : w_fifo_head[PC_W-1:0];
    assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: reset, latency, backpressure, redirect,
// halt, pc wrap and mid-stream reset, with a scoreboard on the decode handshake.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [3:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt_req;
  logic        halted;

  logic [31:0] mem [16];
  logic [47:0] exp_q [$];
  logic [47:0] exp_e;
  int          checks;
  int          errors;

  fetch_prefetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers during the cycle the registered request is presented,
  // so the word is captured on the following edge.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
  end
  assign imem_rdata = mem[imem_addr];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},    {47'd0, imem_en},    48'd0);
    check({tag, "_addr"},  {44'd0, imem_addr},  48'd0);
    check({tag, "_valid"}, {47'd0, inst_valid}, 48'd0);
    check({tag, "_data"},  {16'd0, inst_data},  48'd0);
    check({tag, "_pc"},    {32'd0, inst_pc},    48'd0);
    check({tag, "_halted"},{47'd0, halted},     48'd0);
  endtask

  // scoreboard monitor: every handshake transfer pops one expected {pc, data}
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected actual=%0h expected=none", {inst_pc, inst_data});
      end else begin
        exp_e = exp_q.pop_front();
        check("xfer", {inst_pc, inst_data}, exp_e);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'd0;
    halt_req = 1'b0;

    // reset state
    repeat (3) tick();
    check_idle_outputs("reset");

    // streaming after reset release: pc k transfers on edge 4+k
    for (int k = 0; k < 7; k++) push_exp(16'(k), 32'h100 + k);
    inst_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("lat_e1_valid", {47'd0, inst_valid}, 48'd0);
    check("lat_e1_en", {47'd0, imem_en}, 48'd0);
    tick();
    check("lat_e2_valid", {47'd0, inst_valid}, 48'd0);
    check("lat_e2_en", {47'd0, imem_en}, 48'd1);
    check("lat_e2_addr", {44'd0, imem_addr}, 48'd0);
    tick();
    check("lat_e3_valid", {47'd0, inst_valid}, 48'd1);
    repeat (7) tick();

    // reset mid-stream with a read in flight
    rst = 1'b1;
    inst_ready = 1'b0;
    tick();
    check_idle_outputs("mid_rst");
    check("drain_a", 48'(exp_q.size()), 48'd0);
    tick();

    // backpressure: only FIFO_DEPTH words buffered, fetch stalls
    push_exp(16'd0, 32'h100);
    push_exp(16'd1, 32'h101);
    push_exp(16'd9, 32'h109);
    push_exp(16'd10, 32'h10A);
    rst = 1'b0;
    repeat (10) tick();
    check("full_valid", {47'd0, inst_valid}, 48'd1);
    check("full_head", {inst_pc, inst_data}, {16'd0, 32'h100});
    check("full_en", {47'd0, imem_en}, 48'd0);
    inst_ready = 1'b1;
    tick();
    tick();

    // redirect with FIFO holding pc 2..4 and pc 5 in flight
    check("pre_redir_head", {32'd0, inst_pc}, 48'd2);
    check("pre_redir_addr", {43'd0, imem_en, imem_addr}, {43'd0, 1'b1, 4'd5});
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 16'd9;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", {47'd0, inst_valid}, 48'd0);
    check("redir_en", {47'd0, imem_en}, 48'd0);
    inst_ready = 1'b1;
    tick();
    check("redir_issue", {43'd0, imem_en, imem_addr}, {43'd0, 1'b1, 4'd9});
    tick();
    check("redir_arrive", {47'd0, inst_valid}, 48'd1);
    tick();
    tick();

    // halt with a non-empty FIFO; redirect while halted is ignored
    inst_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_halted", {47'd0, halted}, 48'd1);
    check("halt_valid", {47'd0, inst_valid}, 48'd0);
    inst_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      redirect_valid = (c == 5);
      redirect_target = 16'd3;
      tick();
      check("halted_quiet", {45'd0, imem_en, inst_valid, halted}, {45'd0, 3'b001});
    end
    redirect_valid = 1'b0;
    check("drain_b", 48'(exp_q.size()), 48'd0);

    // reset restarts from pc 0, then redirect to 15 and wrap to address 0
    rst = 1'b1;
    tick();
    check("rst_halt_clear", {47'd0, halted}, 48'd0);
    push_exp(16'd0, 32'h100);
    push_exp(16'd1, 32'h101);
    push_exp(16'd15, 32'h10F);
    push_exp(16'd16, 32'h100);
    push_exp(16'd17, 32'h101);
    push_exp(16'd18, 32'h102);
    rst = 1'b0;
    inst_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_target = 16'd15;
    tick();
    redirect_valid = 1'b0;
    check("wrap_flush_valid", {47'd0, inst_valid}, 48'd0);
    tick();
    check("wrap_issue15", {43'd0, imem_en, imem_addr}, {43'd0, 1'b1, 4'd15});
    tick();
    check("wrap_addr0", {43'd0, imem_en, imem_addr}, {43'd0, 1'b1, 4'd0});
    repeat (4) tick();

    // halt and redirect together: halt wins
    inst_ready = 1'b0;
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 16'd5;
    tick();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    check("both_halted", {47'd0, halted}, 48'd1);
    check("both_valid", {47'd0, inst_valid}, 48'd0);
    repeat (3) tick();
    check("both_en", {47'd0, imem_en}, 48'd0);
    check("drain_c", 48'(exp_q.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
